// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between issue logic and the multiply/divide unit
interface mul_div_unit_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 6
);
  logic                  Start;
  logic [1:0]            Op;
  logic                  Signed_Op;
  logic [WIDTH-1:0]      Operand_A;
  logic [WIDTH-1:0]      Operand_B;
  logic [REG_ADDR_W-1:0] Dest_Reg;
  logic                  Busy;
  logic                  Done;
  logic                  Reg_Write;
  logic [REG_ADDR_W-1:0] Reg_WR;
  logic [WIDTH-1:0]      Write_Data;
  logic                  Div_By_Zero;

  modport master (
    output Start, Op, Signed_Op, Operand_A, Operand_B, Dest_Reg,
    input  Busy, Done, Reg_Write, Reg_WR, Write_Data, Div_By_Zero
  );

  modport slave (
    input  Start, Op, Signed_Op, Operand_A, Operand_B, Dest_Reg,
    output Busy, Done, Reg_Write, Reg_WR, Write_Data, Div_By_Zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiply / restoring divide with register write-back
// Define MDU_SIGNED_EN to build two's-complement support (sign capture and result negation).
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 6
) (
  input  logic          Slow_Clock,
  input  logic          Reset,
  mul_div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_op;
  logic [2*WIDTH-1:0]    r_acc;
  logic [WIDTH-1:0]      r_opnd;
  logic [CNT_W-1:0]      r_count;
  logic                  r_dbz;
  logic [WIDTH-1:0]      r_result;
  logic                  r_done;
  logic                  r_dbz_out;
  logic [WIDTH-1:0]      r_wdata;
  logic [REG_ADDR_W-1:0] r_reg_wr;

  logic                  w_accept;
  logic                  w_b_zero;
  logic [WIDTH-1:0]      w_mag_a;
  logic [WIDTH-1:0]      w_mag_b;
  logic [WIDTH:0]        w_mul_sum;
  logic [WIDTH:0]        w_div_shift;
  logic [WIDTH:0]        w_div_diff;
  logic [2*WIDTH-1:0]    w_prod;
  logic [WIDTH-1:0]      w_quot;
  logic [WIDTH-1:0]      w_rem;
  logic [WIDTH-1:0]      w_fix_result;

  // A Start coinciding with the Done pulse is dropped; the unit takes it one cycle later.
  assign w_accept = (r_state == S_IDLE) && !r_done && bus.Start;
  assign w_b_zero = (bus.Operand_B == '0);

`ifdef MDU_SIGNED_EN
  logic r_sign_a;
  logic r_sign_b;
  logic w_sa;
  logic w_sb;
  assign w_sa    = bus.Signed_Op & bus.Operand_A[WIDTH-1];
  assign w_sb    = bus.Signed_Op & bus.Operand_B[WIDTH-1];
  assign w_mag_a = w_sa ? -bus.Operand_A : bus.Operand_A;
  assign w_mag_b = w_sb ? -bus.Operand_B : bus.Operand_B;
`else
  logic w_unused_signed;
  assign w_unused_signed = bus.Signed_Op;
  assign w_mag_a = bus.Operand_A;
  assign w_mag_b = bus.Operand_B;
`endif

  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};

  always_comb begin
    w_prod = r_acc;
    w_quot = r_acc[WIDTH-1:0];
    w_rem  = r_acc[2*WIDTH-1:WIDTH];
`ifdef MDU_SIGNED_EN
    if (r_sign_a ^ r_sign_b) begin
      w_prod = -r_acc;
      w_quot = -r_acc[WIDTH-1:0];
    end
    if (r_sign_a) begin
      w_rem = -r_acc[2*WIDTH-1:WIDTH];
    end
`endif
    w_fix_result = '0;
    if (r_dbz) begin
      // Divide-by-zero keeps the raw dividend in the low half for REM.
      w_fix_result = r_op[0] ? r_acc[WIDTH-1:0] : '1;
    end else begin
      case (r_op)
        2'b00:   w_fix_result = w_prod[WIDTH-1:0];
        2'b01:   w_fix_result = w_prod[2*WIDTH-1:WIDTH];
        2'b10:   w_fix_result = w_quot;
        default: w_fix_result = w_rem;
      endcase
    end
  end

  always_ff @(posedge Slow_Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (bus.Op[1] && w_b_zero) ? S_FIX : S_CALC;
      S_CALC: if (r_count == CNT_W'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Slow_Clock or posedge Reset) begin
    if (Reset) begin
      r_op      <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_count   <= '0;
      r_dbz     <= 1'b0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      r_wdata   <= '0;
      r_reg_wr  <= '0;
`ifdef MDU_SIGNED_EN
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= bus.Op;
            r_reg_wr <= bus.Dest_Reg;
            r_count  <= CNT_W'(WIDTH);
            r_dbz    <= bus.Op[1] && w_b_zero;
`ifdef MDU_SIGNED_EN
            r_sign_a <= w_sa;
            r_sign_b <= w_sb;
`endif
            // Multiply iterates over the multiplier in the low half; divide shifts the dividend out of it.
            if (bus.Op[1]) begin
              r_acc  <= {{WIDTH{1'b0}}, (w_b_zero ? bus.Operand_A : w_mag_a)};
              r_opnd <= w_mag_b;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
              r_opnd <= w_mag_a;
            end
          end
        end
        S_CALC: begin
          r_count <= r_count - CNT_W'(1);
          if (r_op[1]) begin
            if (!w_div_diff[WIDTH]) begin
              r_acc <= {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
              r_acc <= {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          end
        end
        S_FIX: r_result <= w_fix_result;
        S_DONE: begin
          r_done    <= 1'b1;
          r_wdata   <= r_result;
          r_dbz_out <= r_dbz;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy        = (r_state != S_IDLE) || r_done;
  assign bus.Done        = r_done;
  assign bus.Reg_Write   = r_done && (r_reg_wr != '0);
  assign bus.Reg_WR      = r_reg_wr;
  assign bus.Write_Data  = r_wdata;
  assign bus.Div_By_Zero = r_dbz_out;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed-vector bench for mul_div_unit
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mul_div_unit_if #(.WIDTH(32), .REG_ADDR_W(6)) bus ();

  mul_div_unit #(.WIDTH(32), .REG_ADDR_W(6)) dut (
    .Slow_Clock (clk),
    .Reset      (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Issue one request from an idle unit (called #1 after an edge); returns edges until Done and write count.
  task automatic run_op(input logic [1:0] op, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] dest,
                        output int edges, output int writes);
    bus.Start = 1'b1; bus.Op = op; bus.Signed_Op = sgn;
    bus.Operand_A = a; bus.Operand_B = b; bus.Dest_Reg = dest;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.Operand_A = 32'hDEAD_BEEF; bus.Operand_B = 32'h1234_5678;
    bus.Dest_Reg = 6'd63;
    edges = 0; writes = 0;
    while (edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (bus.Reg_Write) writes++;
      if (bus.Done) break;
    end
  endtask

  task automatic test_reset();
    bus.Start = 1'b0; bus.Op = 2'b00; bus.Signed_Op = 1'b0;
    bus.Operand_A = '0; bus.Operand_B = '0; bus.Dest_Reg = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({bus.Busy, bus.Done, bus.Reg_Write, bus.Div_By_Zero} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.Busy, bus.Done, bus.Reg_Write, bus.Div_By_Zero}); end
    checks++; if (bus.Reg_WR !== 6'd0) begin errors++; $display("FAIL reset_reg_wr: got %0d expected 0", bus.Reg_WR); end
    checks++; if (bus.Write_Data !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.Write_Data); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int e, w;
    run_op(2'b00, 1'b0, 32'd7, 32'd6, 6'd5, e, w);
    checks++; if (e !== 34) begin errors++; $display("FAIL mul_latency: got %0d expected 34", e); end
    checks++; if (bus.Write_Data !== 32'd42) begin errors++; $display("FAIL mul_data: got %h expected 0000002a", bus.Write_Data); end
    checks++; if (bus.Reg_WR !== 6'd5) begin errors++; $display("FAIL mul_reg_wr: got %0d expected 5", bus.Reg_WR); end
    checks++; if (w !== 1) begin errors++; $display("FAIL mul_write_count: got %0d expected 1", w); end
    checks++; if (bus.Div_By_Zero !== 1'b0) begin errors++; $display("FAIL mul_dbz: got %b expected 0", bus.Div_By_Zero); end
    @(posedge clk); #1;
    checks++; if ({bus.Done, bus.Reg_Write, bus.Busy} !== 3'b000) begin errors++; $display("FAIL mul_pulse_end: got %b expected 000", {bus.Done, bus.Reg_Write, bus.Busy}); end
    checks++; if (bus.Write_Data !== 32'd42) begin errors++; $display("FAIL mul_hold: got %h expected 0000002a", bus.Write_Data); end
  endtask

  task automatic test_mulh();
    int e, w;
    run_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1, e, w);
    checks++; if (bus.Write_Data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulh_unsigned: got %h expected fffffffe", bus.Write_Data); end
    @(posedge clk); #1;
    run_op(2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1, e, w);
`ifdef MDU_SIGNED_EN
    checks++; if (bus.Write_Data !== 32'h0000_0000) begin errors++; $display("FAIL mulh_signed: got %h expected 00000000", bus.Write_Data); end
`else
    checks++; if (bus.Write_Data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulh_signed: got %h expected fffffffe", bus.Write_Data); end
`endif
    @(posedge clk); #1;
    run_op(2'b00, 1'b0, 32'h0001_0003, 32'h0002_0005, 6'd1, e, w);
    checks++; if (bus.Write_Data !== 32'h000B_000F) begin errors++; $display("FAIL mul_lo_wide: got %h expected 000b000f", bus.Write_Data); end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    int e, w;
    run_op(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 6'd2, e, w);
    checks++; if (e !== 34) begin errors++; $display("FAIL div_latency: got %0d expected 34", e); end
`ifdef MDU_SIGNED_EN
    checks++; if (bus.Write_Data !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_signed: got %h expected fffffffd", bus.Write_Data); end
`else
    checks++; if (bus.Write_Data !== 32'h7FFF_FFFC) begin errors++; $display("FAIL div_signed: got %h expected 7ffffffc", bus.Write_Data); end
`endif
    @(posedge clk); #1;
    run_op(2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2, 6'd2, e, w);
`ifdef MDU_SIGNED_EN
    checks++; if (bus.Write_Data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_signed: got %h expected ffffffff", bus.Write_Data); end
`else
    checks++; if (bus.Write_Data !== 32'h0000_0001) begin errors++; $display("FAIL rem_signed: got %h expected 00000001", bus.Write_Data); end
`endif
    @(posedge clk); #1;
    run_op(2'b10, 1'b0, 32'd100, 32'd7, 6'd2, e, w);
    checks++; if (bus.Write_Data !== 32'd14) begin errors++; $display("FAIL div_unsigned: got %h expected 0000000e", bus.Write_Data); end
    checks++; if (bus.Div_By_Zero !== 1'b0) begin errors++; $display("FAIL div_dbz_clear: got %b expected 0", bus.Div_By_Zero); end
    @(posedge clk); #1;
    run_op(2'b11, 1'b0, 32'd100, 32'd7, 6'd2, e, w);
    checks++; if (bus.Write_Data !== 32'd2) begin errors++; $display("FAIL rem_unsigned: got %h expected 00000002", bus.Write_Data); end
    @(posedge clk); #1;
    run_op(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd2, e, w);
`ifdef MDU_SIGNED_EN
    checks++; if (bus.Write_Data !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow: got %h expected 80000000", bus.Write_Data); end
`else
    checks++; if (bus.Write_Data !== 32'h0000_0000) begin errors++; $display("FAIL div_overflow: got %h expected 00000000", bus.Write_Data); end
`endif
    @(posedge clk); #1;
    run_op(2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd2, e, w);
`ifdef MDU_SIGNED_EN
    checks++; if (bus.Write_Data !== 32'h0000_0000) begin errors++; $display("FAIL rem_overflow: got %h expected 00000000", bus.Write_Data); end
`else
    checks++; if (bus.Write_Data !== 32'h8000_0000) begin errors++; $display("FAIL rem_overflow: got %h expected 80000000", bus.Write_Data); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int e, w;
    run_op(2'b10, 1'b0, 32'd100, 32'd0, 6'd9, e, w);
    checks++; if (e !== 2) begin errors++; $display("FAIL dbz_latency: got %0d expected 2", e); end
    checks++; if (bus.Write_Data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_quot: got %h expected ffffffff", bus.Write_Data); end
    checks++; if (bus.Div_By_Zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", bus.Div_By_Zero); end
    @(posedge clk); #1;
    checks++; if (bus.Div_By_Zero !== 1'b0) begin errors++; $display("FAIL dbz_flag_after: got %b expected 0", bus.Div_By_Zero); end
    run_op(2'b11, 1'b0, 32'd100, 32'd0, 6'd9, e, w);
    checks++; if (bus.Write_Data !== 32'd100) begin errors++; $display("FAIL dbz_rem: got %h expected 00000064", bus.Write_Data); end
    checks++; if (bus.Div_By_Zero !== 1'b1) begin errors++; $display("FAIL dbz_rem_flag: got %b expected 1", bus.Div_By_Zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_reset();
    int dones, writes, e, w;
    logic [31:0] wd;
    dones = 0; writes = 0; wd = '0;
    bus.Start = 1'b1; bus.Op = 2'b00; bus.Signed_Op = 1'b0;
    bus.Operand_A = 32'd7; bus.Operand_B = 32'd9; bus.Dest_Reg = 6'd3;
    @(posedge clk); #1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 3 || c == 20) begin
        bus.Start = 1'b1; bus.Op = 2'b01; bus.Operand_A = 32'd11; bus.Operand_B = 32'd13;
      end else begin
        bus.Start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.Done) begin dones++; wd = bus.Write_Data; end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", dones); end
    checks++; if (wd !== 32'd63) begin errors++; $display("FAIL busy_result: got %h expected 0000003f", wd); end

    bus.Start = 1'b1; bus.Op = 2'b00; bus.Operand_A = 32'd2; bus.Operand_B = 32'd2; bus.Dest_Reg = 6'd4;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.Busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.Reg_Write || bus.Done) writes++;
    end
    checks++; if (writes !== 0) begin errors++; $display("FAIL abort_no_write: got %0d expected 0", writes); end
    checks++; if (bus.Write_Data !== 32'd0) begin errors++; $display("FAIL abort_wdata: got %h expected 0", bus.Write_Data); end
    run_op(2'b00, 1'b0, 32'd3, 32'd3, 6'd4, e, w);
    checks++; if (bus.Write_Data !== 32'd9) begin errors++; $display("FAIL after_abort_mul: got %h expected 00000009", bus.Write_Data); end
    @(posedge clk); #1;
  endtask

  task automatic test_dest_zero();
    int e, w;
    run_op(2'b00, 1'b0, 32'd5, 32'd5, 6'd0, e, w);
    checks++; if (e !== 34) begin errors++; $display("FAIL dest0_done: got %0d expected 34", e); end
    checks++; if (bus.Write_Data !== 32'd25) begin errors++; $display("FAIL dest0_data: got %h expected 00000019", bus.Write_Data); end
    checks++; if (w !== 0) begin errors++; $display("FAIL dest0_no_write: got %0d expected 0", w); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int e, w;
    run_op(2'b00, 1'b0, 32'd6, 32'd8, 6'd7, e, w);
    checks++; if (bus.Write_Data !== 32'd48) begin errors++; $display("FAIL b2b_first: got %h expected 00000030", bus.Write_Data); end
    // Start held from the Done cycle: dropped at the next edge, taken at the one after.
    bus.Start = 1'b1; bus.Op = 2'b00; bus.Operand_A = 32'd3; bus.Operand_B = 32'd4; bus.Dest_Reg = 6'd8;
    @(posedge clk); #1;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored: got busy=%b expected 0", bus.Busy); end
    run_op(2'b00, 1'b0, 32'd3, 32'd4, 6'd8, e, w);
    checks++; if (e !== 34) begin errors++; $display("FAIL b2b_latency: got %0d expected 34", e); end
    checks++; if (bus.Write_Data !== 32'd12) begin errors++; $display("FAIL b2b_second: got %h expected 0000000c", bus.Write_Data); end
    checks++; if (bus.Reg_WR !== 6'd8) begin errors++; $display("FAIL b2b_reg_wr: got %0d expected 8", bus.Reg_WR); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_zero();
    test_busy_reset();
    test_dest_zero();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
